// File: rtl/mig_tt_checker.sv
// Exhaustive truth-table checker for a MIG netlist: walks pi through every pattern and compares po0.
// Optional observed-table capture is enabled by defining MIG_CHK_CAPTURE_EN.
module mig_tt_checker #(
  parameter int N_PI   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_PI-1:0]   exp_tt,
  output logic [N_PI-1:0]      pi,
  input  logic                 po0,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_PI:0]        fail_count,
  output logic                 first_fail_vld,
  output logic [N_PI-1:0]      first_fail_idx,
  output logic [2**N_PI-1:0]   obs_tt
);

  localparam int              TT_W      = 2**N_PI;
  localparam logic [N_PI-1:0] IDX_ZERO  = N_PI'(0);
  localparam logic [N_PI-1:0] IDX_ONE   = N_PI'(1);
  localparam logic [N_PI-1:0] IDX_LAST  = N_PI'(TT_W - 1);
  localparam logic [N_PI:0]   FC_ZERO   = (N_PI+1)'(0);
  localparam logic [N_PI:0]   FC_MAX    = (N_PI+1)'(TT_W);
  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_r;
  logic [N_PI-1:0]   idx_r;
  logic [3:0]        wait_r;
  logic [TT_W-1:0]   exp_r;
  logic              start_acc_s;
  logic              mismatch_s;
  logic [N_PI:0]     fail_next_s;

  // Accepted start, current-pattern mismatch and the saturating next fail count.
  always_comb begin
    start_acc_s = 1'b0;
    mismatch_s  = 1'b0;
    fail_next_s = fail_count;
    if ((state_r == S_IDLE) || (state_r == S_DONE)) begin
      start_acc_s = start & ~abort;
    end else begin
      start_acc_s = 1'b0;
    end
    if (state_r == S_SAMPLE) begin
      mismatch_s = po0 ^ exp_r[idx_r];
    end else begin
      mismatch_s = 1'b0;
    end
    if (fail_count != FC_MAX) begin
      fail_next_s = fail_count + (N_PI+1)'(mismatch_s);
    end else begin
      fail_next_s = fail_count;
    end
  end

  // Main sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      idx_r          <= IDX_ZERO;
      wait_r         <= 4'd0;
      exp_r          <= {TT_W{1'b0}};
      pi             <= IDX_ZERO;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= FC_ZERO;
      first_fail_vld <= 1'b0;
      first_fail_idx <= IDX_ZERO;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start_acc_s) begin
            exp_r          <= exp_tt;
            idx_r          <= IDX_ZERO;
            pi             <= IDX_ZERO;
            fail_count     <= FC_ZERO;
            first_fail_vld <= 1'b0;
            first_fail_idx <= IDX_ZERO;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            wait_r         <= SETTLE_LD;
            state_r        <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state_r <= S_IDLE;
            pi      <= IDX_ZERO;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            wait_r  <= 4'd0;
          end else if (wait_r == 4'd0) begin
            state_r <= S_SAMPLE;
          end else begin
            wait_r <= wait_r - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            state_r <= S_IDLE;
            pi      <= IDX_ZERO;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            wait_r  <= 4'd0;
          end else begin
            fail_count <= fail_next_s;
            if (mismatch_s && !first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_idx <= idx_r;
            end
            // idx stops at the last pattern rather than wrapping.
            if (idx_r != IDX_LAST) begin
              idx_r   <= idx_r + IDX_ONE;
              pi      <= idx_r + IDX_ONE;
              wait_r  <= SETTLE_LD;
              state_r <= S_SETTLE;
            end else begin
              state_r <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (fail_next_s == FC_ZERO);
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          pi      <= IDX_ZERO;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
          wait_r  <= 4'd0;
        end
      endcase
    end
  end

`ifdef MIG_CHK_CAPTURE_EN
  logic [TT_W-1:0] obs_r;

  // Observed truth table: bit idx takes po0 at each sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_r <= {TT_W{1'b0}};
    end else if (start_acc_s) begin
      obs_r <= {TT_W{1'b0}};
    end else if ((state_r == S_SAMPLE) && !abort) begin
      obs_r[idx_r] <= po0;
    end
  end

  assign obs_tt = obs_r;
`else
  assign obs_tt = {TT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mig_tt_checker.sv
// Directed self-checking bench for mig_tt_checker (N_PI=4, SETTLE=1) with a small MIG netlist model.
module tb_mig_tt_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] exp_tt = 16'h0000;
  logic [3:0]  pi;
  logic        po0;
  logic        busy, done, pass, first_fail_vld;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail_idx;
  logic [15:0] obs_tt;
  logic        stuck = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;

  always #5 clk = ~clk;

  // Netlist under test: AND(~pi0, ~pi1, pi2, pi3), or stuck-at-1.
  assign po0 = stuck ? 1'b1 : (~pi[0] & ~pi[1] & pi[2] & pi[3]);

  mig_tt_checker #(.N_PI(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tt(exp_tt),
    .pi(pi), .po0(po0), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_vld(first_fail_vld),
    .first_fail_idx(first_fail_idx), .obs_tt(obs_tt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic go(input logic [15:0] tt);
    @(negedge clk);
    exp_tt = tt;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Counts edges from the start edge until done; optionally pulses start (with junk exp_tt) while busy.
  task automatic wait_done(input bit pulse, output int n);
    n = 0;
    while (!done && n < 200) begin
      if (pulse && (n == 10 || n == 25)) begin
        start  = 1'b1;
        exp_tt = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic wait_pi(input logic [3:0] target);
    int n = 0;
    while (pi != target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_pi", {28'd0, pi}, {28'd0, target});
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_pi",   {28'd0, pi},   32'd0);
    chk("rst_fc",   {27'd0, fail_count}, 32'd0);
    chk("rst_obs",  {16'd0, obs_tt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Matching table
    go(16'h1000);
    chk("m_busy", {31'd0, busy}, 32'd1);
    chk("m_pi0",  {28'd0, pi},   32'd0);
    wait_done(1'b0, cyc);
    chk("m_cycles", cyc, 32'd48);
    chk("m_pass", {31'd0, pass}, 32'd1);
    chk("m_fc",   {27'd0, fail_count}, 32'd0);
    chk("m_ffv",  {31'd0, first_fail_vld}, 32'd0);
    chk("m_busy_done", {31'd0, busy}, 32'd0);
`ifdef MIG_CHK_CAPTURE_EN
    chk("m_obs", {16'd0, obs_tt}, 32'h1000);
`else
    chk("m_obs", {16'd0, obs_tt}, 32'd0);
`endif

    // Single-bit expectation error
    go(16'h1001);
    wait_done(1'b0, cyc);
    chk("e_cycles", cyc, 32'd48);
    chk("e_pass", {31'd0, pass}, 32'd0);
    chk("e_fc",   {27'd0, fail_count}, 32'd1);
    chk("e_ffv",  {31'd0, first_fail_vld}, 32'd1);
    chk("e_ffi",  {28'd0, first_fail_idx}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("e_hold_done", {31'd0, done}, 32'd1);
    chk("e_hold_fc",   {27'd0, fail_count}, 32'd1);

    // Restart from DONE with a stuck-at-1 output
    stuck = 1'b1;
    go(16'h0000);
    chk("s_done_clr", {31'd0, done}, 32'd0);
    chk("s_fc_clr",   {27'd0, fail_count}, 32'd0);
    wait_done(1'b0, cyc);
    chk("s_cycles", cyc, 32'd48);
    chk("s_fc",   {27'd0, fail_count}, 32'd16);
    chk("s_ffi",  {28'd0, first_fail_idx}, 32'd0);
    chk("s_pass", {31'd0, pass}, 32'd0);
`ifdef MIG_CHK_CAPTURE_EN
    chk("s_obs", {16'd0, obs_tt}, 32'hFFFF);
`else
    chk("s_obs", {16'd0, obs_tt}, 32'd0);
`endif

    // Abort during pattern 5 (patterns 0..4 already failed)
    go(16'h0000);
    wait_pi(4'd5);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("a_busy", {31'd0, busy}, 32'd0);
    chk("a_done", {31'd0, done}, 32'd0);
    chk("a_pi",   {28'd0, pi},   32'd0);
    chk("a_fc",   {27'd0, fail_count}, 32'd5);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b0;
    chk("a_idle_busy", {31'd0, busy}, 32'd0);
    chk("a_idle_fc",   {27'd0, fail_count}, 32'd5);
    stuck = 1'b0;
    go(16'h1000);
    chk("a_re_pi", {28'd0, pi}, 32'd0);
    wait_done(1'b0, cyc);
    chk("a_re_cycles", cyc, 32'd48);
    chk("a_re_pass", {31'd0, pass}, 32'd1);

    // Abort and start together: abort wins
    go(16'h1000);
    wait_pi(4'd2);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    chk("p_busy", {31'd0, busy}, 32'd0);
    chk("p_done", {31'd0, done}, 32'd0);

    // Ignored start pulses while busy keep timing and latched table
    go(16'h1000);
    wait_done(1'b1, cyc);
    chk("i_cycles", cyc, 32'd48);
    chk("i_pass", {31'd0, pass}, 32'd1);
    chk("i_fc",   {27'd0, fail_count}, 32'd0);

    // Reset mid-run during pattern 9
    go(16'h1000);
    wait_pi(4'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_pi",   {28'd0, pi},   32'd0);
    chk("r_done", {31'd0, done}, 32'd0);
    chk("r_ffv",  {31'd0, first_fail_vld}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    go(16'h1000);
    wait_done(1'b0, cyc);
    chk("r_cycles", cyc, 32'd48);
    chk("r_pass", {31'd0, pass}, 32'd1);
    chk("r_fc",   {27'd0, fail_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mig_tt_checker.md
MIG_TT_CHECKER -- requirements
Module: mig_tt_checker

Interface
REQ-001 SHALL have parameter N_PI, default 4, giving the number of primary inputs driven into the MIG netlist under test (legal range 1..8).
REQ-002 SHALL have parameter SETTLE, default 1, giving the number of extra wait cycles between driving a pattern and sampling po0 (legal range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port start, input, 1 bit: request for a new exhaustive check run.
REQ-006 SHALL have port abort, input, 1 bit: cancels the run in progress.
REQ-007 SHALL have port exp_tt, input, 2^N_PI bits: expected truth table, where bit i is the expected po0 when pi equals i.
REQ-008 SHALL have port pi, output, N_PI bits: pattern driven to pi0..pi(N_PI-1) of the netlist, with pi[0] mapping to pi0.
REQ-009 SHALL have port po0, input, 1 bit: netlist output being checked.
REQ-010 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-011 SHALL have port done, output, 1 bit: level signal, high after a run completes.
REQ-012 SHALL have port pass, output, 1 bit: qualified by done, high when fail_count is 0.
REQ-013 SHALL have port fail_count, output, N_PI+1 bits: number of mismatching patterns in the run.
REQ-014 SHALL have port first_fail_vld, output, 1 bit, and port first_fail_idx, output, N_PI bits: together they give the lowest pattern index that mismatched.

Function
REQ-015 SHALL implement the states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 SHALL, when start=1 in IDLE or DONE, on that edge:
- latch exp_tt into an internal register;
- clear idx, pi, fail_count and first_fail_vld, and clear done;
- load the wait counter with SETTLE;
- enter SETTLE.
REQ-017 SHALL ignore start while busy=1; a later change on exp_tt SHALL NOT affect a run in progress.
REQ-018 SHALL, in SETTLE, hold pi and decrement the wait counter, moving to SAMPLE on the edge where the counter equals 0 (SETTLE+1 cycles in SETTLE).
REQ-019 SHALL, in SAMPLE, compare po0 against latched bit idx of the expected table; on a mismatch it SHALL increment fail_count and, if first_fail_vld=0, set first_fail_vld=1 and first_fail_idx=idx.
REQ-020 SHALL, in SAMPLE, choose the next state by idx:
- idx below 2^N_PI-1: increment idx, drive pi to the new idx, reload the wait counter with SETTLE, return to SETTLE;
- otherwise: enter DONE.
REQ-021 SHALL ensure idx never wraps; the last pattern is 2^N_PI-1, and fail_count reaching 2^N_PI SHALL NOT overflow.
REQ-022 SHALL assert done and hold pass, fail_count and first_fail_* stable in DONE until the next accepted start.
REQ-023 SHALL assert done exactly 2^N_PI*(SETTLE+2) cycles after the accepting start edge.
REQ-024 SHALL, when abort=1 while busy, enter IDLE on that edge with pi=0 and done=0, and SHALL keep the partial fail_count visible.
REQ-025 SHALL give abort priority over start when both are high in the same cycle; abort in IDLE or DONE SHALL have no effect.
REQ-026 SHALL drive busy=1 exactly in SETTLE and SAMPLE, and pass=done&(fail_count==0).

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=IDLE, pi=0, idx=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vld=0, first_fail_idx=0 and the wait counter to 0.
REQ-028 SHALL, on reset mid-run, discard the run; after rst_n deasserts, the first start SHALL behave as REQ-016.

Configuration
REQ-029 SHALL, when MIG_CHK_CAPTURE_EN is defined, provide output obs_tt (2^N_PI bits), cleared on accepted start and reset, with bit idx written with po0 in each SAMPLE.
REQ-030 SHALL, when MIG_CHK_CAPTURE_EN is undefined, still present obs_tt but tie it constant 0, with no capture register.

Verification
REQ-031 SHALL cover the matching case: N_PI=4, SETTLE=1, po0 = AND of ~pi0,~pi1,pi2,pi3, exp_tt=16'h1000 -> done 48 cycles after start, pass=1, fail_count=0, first_fail_vld=0.
REQ-032 SHALL cover a single-bit expectation error: same netlist, exp_tt=16'h1001 -> pass=0, fail_count=1, first_fail_idx=0.
REQ-033 SHALL cover a stuck-at output: po0 stuck at 1, exp_tt=16'h0000 -> fail_count=16, first_fail_idx=0; with capture on, obs_tt=16'hFFFF.
REQ-034 SHALL cover abort: abort asserted during pattern 5 -> IDLE on the next edge, done=0, pi=0; the following start runs the full check from idx 0.
REQ-035 SHALL cover reset mid-run: rst_n pulsed low during pattern 9 -> all outputs 0 immediately; a start after deassertion gives the REQ-031 result.
REQ-036 SHALL cover restart and ignored start: start in DONE restarts with done cleared on that edge, and start pulses while busy leave the completion cycle unchanged.
